restoring_divider: RTL

Multi-cycle integer divider that computes quotient and remainder one bit per cycle using restoring division. It is the inverse-operation companion to the team's adder: each iteration performs a trial subtraction on an internal WIDTH+1-bit ripple-carry datapath. It serves as the execution unit for RISC-V DIV/DIVU/REM/REMU and follows the ISA's divide-by-zero and signed-overflow semantics. Operands arrive and results leave through valid/ready handshakes.

---
 rtl/restoring_divider_pkg.sv | 21 ++
 rtl/restoring_divider_if.sv | 34 +++
 rtl/restoring_divider_trial_subtractor.sv | 29 ++
 rtl/restoring_divider.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared types and constants for the restoring divider.
//   state_t       : divider control states
//   DEFAULT_WIDTH : default operand/result width
//   QUO_ALL_ONES  : divide-by-zero quotient at the default width
//   MOST_NEG      : most-negative two's-complement value at the default width
// Instances that change WIDTH derive the same constants locally with all_ones()/most_neg() patterns.
package restoring_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FIXUP  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [DEFAULT_WIDTH-1:0] QUO_ALL_ONES = '1;
  localparam logic [DEFAULT_WIDTH-1:0] MOST_NEG     = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/restoring_divider_if.sv
// Operand/result handshake bundle for the restoring divider.
//   in_valid/in_ready   : operand handshake (dividend, divisor, is_signed)
//   out_valid/out_ready : result handshake (quotient, remainder, div_by_zero, overflow)
//   master : producer of operands / consumer of results
//   slave  : the divider
interface restoring_divider_if
  import restoring_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/restoring_divider_trial_subtractor.sv
// Trial subtraction o_diff = i_a - i_b as a ripple chain of full adders
// (b inverted, carry-in 1). o_carry = 1 means i_a >= i_b (unsigned).
//   i_a, i_b : N-bit operands
//   o_diff   : N-bit difference
//   o_carry  : carry out of the top adder
module restoring_divider_trial_subtractor #(
  parameter int unsigned N = 65
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_carry
);

  logic [N:0]   w_c;
  logic [N-1:0] w_b_n;

  assign w_c[0] = 1'b1;
  assign w_b_n  = ~i_b;

  // One full adder per bit.
  for (genvar g = 0; g < N; g++) begin : g_fa
    assign o_diff[g] = i_a[g] ^ w_b_n[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & w_b_n[g]) | (i_a[g] & w_c[g]) | (w_b_n[g] & w_c[g]);
  end

  assign o_carry = w_c[N];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, with RISC-V
// DIV/DIVU/REM/REMU semantics for divide-by-zero and signed overflow.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of restoring_divider_if (operands in, results out)
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  restoring_divider_if.slave  bus
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] NEG_MAX  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state,       w_state_nxt;
  logic [WIDTH:0]   r_rem,         w_rem_nxt;
  logic [WIDTH-1:0] r_quo,         w_quo_nxt;
  logic [WIDTH-1:0] r_dvs,         w_dvs_nxt;
  logic [CNT_W-1:0] r_cnt,         w_cnt_nxt;
  logic             r_neg_q,       w_neg_q_nxt;
  logic             r_neg_r,       w_neg_r_nxt;
  logic             r_in_ready,    w_in_ready_nxt;
  logic             r_out_valid,   w_out_valid_nxt;
  logic [WIDTH-1:0] r_quotient,    w_quotient_nxt;
  logic [WIDTH-1:0] r_remainder,   w_remainder_nxt;
  logic             r_div_by_zero, w_div_by_zero_nxt;
  logic             r_overflow,    w_overflow_nxt;

  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_carry;
  logic [WIDTH-1:0] w_dividend_abs;
  logic [WIDTH-1:0] w_divisor_abs;
  logic [WIDTH-1:0] w_quo_neg;
  logic [WIDTH-1:0] w_rem_neg;
  logic             w_unused_rem_msb;

  // Partial remainder is always below the divisor, so its top bit stays zero.
  assign w_unused_rem_msb = r_rem[WIDTH];

  assign w_rem_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};

  restoring_divider_trial_subtractor #(
    .N (WIDTH + 1)
  ) u_trial_sub (
    .i_a     (w_rem_shift),
    .i_b     ({1'b0, r_dvs}),
    .o_diff  (w_diff),
    .o_carry (w_carry)
  );

  // Absolute values and final sign fixups share the invert-plus-one form.
  assign w_dividend_abs = (bus.is_signed & bus.dividend[WIDTH-1]) ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
  assign w_divisor_abs  = (bus.is_signed & bus.divisor[WIDTH-1])  ? (~bus.divisor + WIDTH'(1))  : bus.divisor;
  assign w_quo_neg      = ~r_quo + WIDTH'(1);
  assign w_rem_neg      = ~r_rem[WIDTH-1:0] + WIDTH'(1);

  // Next-state and datapath next values.
  always_comb begin
    w_state_nxt       = r_state;
    w_rem_nxt         = r_rem;
    w_quo_nxt         = r_quo;
    w_dvs_nxt         = r_dvs;
    w_cnt_nxt         = r_cnt;
    w_neg_q_nxt       = r_neg_q;
    w_neg_r_nxt       = r_neg_r;
    w_quotient_nxt    = r_quotient;
    w_remainder_nxt   = r_remainder;
    w_div_by_zero_nxt = r_div_by_zero;
    w_overflow_nxt    = r_overflow;

    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_neg_q_nxt       = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          w_neg_r_nxt       = bus.is_signed & bus.dividend[WIDTH-1];
          w_div_by_zero_nxt = 1'b0;
          w_overflow_nxt    = 1'b0;
          if (bus.divisor == '0) begin
            w_quotient_nxt    = ALL_ONES;
            w_remainder_nxt   = bus.dividend;
            w_div_by_zero_nxt = 1'b1;
            w_state_nxt       = S_DONE;
          end else if (bus.is_signed && (bus.dividend == NEG_MAX) && (bus.divisor == ALL_ONES)) begin
            w_quotient_nxt    = bus.dividend;
            w_remainder_nxt   = '0;
            w_overflow_nxt    = 1'b1;
            w_state_nxt       = S_DONE;
          end else begin
            w_rem_nxt   = '0;
            w_quo_nxt   = w_dividend_abs;
            w_dvs_nxt   = w_divisor_abs;
            w_cnt_nxt   = CNT_W'(WIDTH - 1);
            w_state_nxt = S_DIVIDE;
          end
        end
      end

      S_DIVIDE: begin
        // Keep the difference when it did not borrow, otherwise restore.
        w_rem_nxt = w_carry ? w_diff : w_rem_shift;
        w_quo_nxt = {r_quo[WIDTH-2:0], w_carry};
        if (r_cnt == '0) begin
          w_state_nxt = S_FIXUP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_FIXUP: begin
        w_quotient_nxt  = r_neg_q ? w_quo_neg : r_quo;
        w_remainder_nxt = r_neg_r ? w_rem_neg : r_rem[WIDTH-1:0];
        w_state_nxt     = S_DONE;
      end

      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Handshake outputs are registered copies of the upcoming state.
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_cnt         <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rem         <= w_rem_nxt;
      r_quo         <= w_quo_nxt;
      r_dvs         <= w_dvs_nxt;
      r_cnt         <= w_cnt_nxt;
      r_neg_q       <= w_neg_q_nxt;
      r_neg_r       <= w_neg_r_nxt;
      r_in_ready    <= w_in_ready_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_quotient    <= w_quotient_nxt;
      r_remainder   <= w_remainder_nxt;
      r_div_by_zero <= w_div_by_zero_nxt;
      r_overflow    <= w_overflow_nxt;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;
  assign bus.overflow    = r_overflow;

endmodule
